// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register word offsets, reset values,
// bus handshake states and the half-word write helper.
package mtimer_pkg;

    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

    localparam logic [63:0] MTIME_RESET    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    // Replace one 32-bit half of a 64-bit register, leaving the other half intact.
    function automatic logic [63:0] write_half(input logic [63:0] old,
                                               input logic        upper,
                                               input logic [31:0] data);
        logic [63:0] result;
        result = old;
        if (upper) result[63:32] = data;
        else       result[31:0]  = data;
        return result;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescale counter for the machine timer: pc runs 0..PRESCALE-1 and tick marks
// the last count, so mtime advances once every PRESCALE clk cycles.
module mtimer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [15:0] PC_LAST = 16'(PRESCALE - 1);

    logic [15:0] pc;

    assign tick = (pc == PC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + 16'd1;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a 32-bit req/ack register port,
// with a level interrupt raised while mtime >= mtimecmp.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        irq_mtimecmp
);

    bus_state_t  state;
    bus_state_t  state_next;
    logic        accept;
    logic        tick;
    logic        wr_en;
    logic        wr_mtime;
    logic        wr_cmp;
    logic        wr_upper;
    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp;
    logic [63:0] mtimecmp_next;
    logic [31:0] read_word;

    mtimer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request is only taken while idle, so the ack cycle blocks back-to-back accepts.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (state == BUS_IDLE) begin
            if (req) begin
                accept     = 1'b1;
                state_next = BUS_ACK;
            end
        end else begin
            state_next = BUS_IDLE;
        end
    end

    assign ack      = (state == BUS_ACK);
    assign wr_en    = accept && we;
    assign wr_mtime = wr_en && ((addr == MTIME_LO) || (addr == MTIME_HI));
    assign wr_cmp   = wr_en && ((addr == MTIMECMP_LO) || (addr == MTIMECMP_HI));
    assign wr_upper = (addr == MTIME_HI) || (addr == MTIMECMP_HI);

    always_comb begin
        read_word = mtime[31:0];
        case (addr)
            MTIME_LO:    read_word = mtime[31:0];
            MTIME_HI:    read_word = mtime[63:32];
            MTIMECMP_LO: read_word = mtimecmp[31:0];
            MTIMECMP_HI: read_word = mtimecmp[63:32];
            default:     read_word = mtime[31:0];
        endcase
    end

    // A software write to mtime wins over a coincident tick; that increment is lost.
    always_comb begin
        mtime_next = mtime;
        if (wr_mtime) begin
            mtime_next = write_half(mtime, wr_upper, wdata);
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_next = mtimecmp;
        if (wr_cmp) begin
            mtimecmp_next = write_half(mtimecmp, wr_upper, wdata);
        end
    end

    // irq compares the registered values, so it lags any register change by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime        <= MTIME_RESET;
            mtimecmp     <= MTIMECMP_RESET;
            irq_mtimecmp <= 1'b0;
            rdata        <= '0;
        end else begin
            mtime        <= mtime_next;
            mtimecmp     <= mtimecmp_next;
            irq_mtimecmp <= (mtime >= mtimecmp);
            if (accept) begin
                rdata <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: two instances (PRESCALE 1 and 4) driven by directed
// and random bus traffic, compared against an arithmetic model of time and registers.
module tb_mtimer;

    localparam int P0 = 1;
    localparam int P1 = 4;

    logic        clk;
    logic        reset;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [1:0]  addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        ack_s   [2];
    logic [31:0] rdata_s [2];
    logic        irq_s   [2];

    int checks = 0;
    int errors = 0;
    int edge_n;

    // Model: mtime after edge n = base + (ticks in (base_edge, n]); ticks fall on edges k with k % P == 0.
    logic [63:0] base           [2];
    logic [63:0] base_prev      [2];
    int          base_edge      [2];
    int          base_edge_prev [2];
    logic [63:0] cmp            [2];
    logic [63:0] cmp_prev       [2];
    int          cmp_edge       [2];

    mtimer #(.PRESCALE(P0)) dut_p1 (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]), .irq_mtimecmp(irq_s[0])
    );

    mtimer #(.PRESCALE(P1)) dut_p4 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]), .irq_mtimecmp(irq_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    function automatic int psc_of(input int d);
        return (d == 0) ? P0 : P1;
    endfunction

    function automatic logic [63:0] model_mtime(input int d, input int n);
        logic [63:0] b;
        int          e;
        if (n >= base_edge[d]) begin
            b = base[d];
            e = base_edge[d];
        end else begin
            b = base_prev[d];
            e = base_edge_prev[d];
        end
        return b + 64'(n / psc_of(d) - e / psc_of(d));
    endfunction

    function automatic logic [63:0] model_cmp(input int d, input int n);
        return (n >= cmp_edge[d]) ? cmp[d] : cmp_prev[d];
    endfunction

    function automatic logic model_irq(input int d, input int n);
        if (n < 1) return 1'b0;
        return model_mtime(d, n - 1) >= model_cmp(d, n - 1);
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [1:0] a, input int n);
        logic [63:0] v;
        v = (a >= 2'd2) ? model_cmp(d, n) : model_mtime(d, n);
        return (a == 2'd1 || a == 2'd3) ? v[63:32] : v[31:0];
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            base[d]           = 64'd0;
            base_prev[d]      = 64'd0;
            base_edge[d]      = 0;
            base_edge_prev[d] = 0;
            cmp[d]            = 64'hFFFF_FFFF_FFFF_FFFF;
            cmp_prev[d]       = 64'hFFFF_FFFF_FFFF_FFFF;
            cmp_edge[d]       = 0;
        end
    endtask

    task automatic modelWrite(input int d, input logic [1:0] a, input logic [31:0] wd, input int w);
        logic [63:0] v;
        if (a < 2'd2) begin
            v = model_mtime(d, w - 1);
            if (a == 2'd1) v[63:32] = wd;
            else           v[31:0]  = wd;
            base_prev[d]      = base[d];
            base_edge_prev[d] = base_edge[d];
            base[d]           = v;
            base_edge[d]      = w;
        end else begin
            v = cmp[d];
            if (a == 2'd3) v[63:32] = wd;
            else           v[31:0]  = wd;
            cmp_prev[d] = cmp[d];
            cmp[d]      = v;
            cmp_edge[d] = w;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIrqs();
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("irq%0d@%0d", d, edge_n), {63'd0, irq_s[d]}, {63'd0, model_irq(d, edge_n)});
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            checkIrqs();
            for (int d = 0; d < 2; d++)
                checkOutput($sformatf("idle_ack%0d", d), {63'd0, ack_s[d]}, 64'd0);
        end
    endtask

    // Idle until the next applyStimulus on dut d will be accepted on an edge with edge % P == res.
    task automatic waitAlign(input int d, input int res);
        while (((edge_n + 2) % psc_of(d)) != res) idle(1);
    endtask

    task automatic applyStimulus(input int d, input logic w, input logic [1:0] a,
                                 input logic [31:0] wd, input string tag,
                                 output logic [31:0] rd);
        logic [31:0] exp;
        int          acc;
        @(negedge clk);
        req_s[d]   = 1'b1;
        we_s[d]    = w;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        @(negedge clk);
        acc        = edge_n;
        req_s[d]   = 1'b0;
        we_s[d]    = 1'b0;
        addr_s[d]  = 2'($urandom);
        wdata_s[d] = $urandom;
        exp        = model_word(d, a, acc - 1);
        rd         = rdata_s[d];
        checkOutput({tag, ".ack"}, {63'd0, ack_s[d]}, 64'd1);
        checkOutput({tag, ".rdata"}, {32'd0, rd}, {32'd0, exp});
        if (w) modelWrite(d, a, wd, acc);
        checkIrqs();
        @(negedge clk);
        checkOutput({tag, ".ackdrop"}, {63'd0, ack_s[d]}, 64'd0);
        checkOutput({tag, ".rhold"}, {32'd0, rdata_s[d]}, {32'd0, exp});
        checkIrqs();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 2; d++) req_s[d] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst_ack%0d", d), {63'd0, ack_s[d]}, 64'd0);
            checkOutput($sformatf("rst_rdata%0d", d), {32'd0, rdata_s[d]}, 64'd0);
            checkOutput($sformatf("rst_irq%0d", d), {63'd0, irq_s[d]}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          acks;
        int          d;
        logic        w;
        logic [1:0]  a;
        logic [31:0] wd;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = 2'd0; wdata_s[i] = 32'd0;
        end
        modelReset();
        $display("[TB] starting mtimer bench");

        // Reset values of mtimecmp.
        doReset();
        applyStimulus(0, 1'b0, 2'd2, 32'd0, "cmp_lo_rst", rd);
        checkOutput("cmp_lo_rst_const", {32'd0, rd}, 64'hFFFF_FFFF);
        applyStimulus(0, 1'b0, 2'd3, 32'd0, "cmp_hi_rst", rd);
        checkOutput("cmp_hi_rst_const", {32'd0, rd}, 64'hFFFF_FFFF);

        // Compare at 10 with PRESCALE=1, then push mtimecmp far away.
        doReset();
        applyStimulus(0, 1'b1, 2'd2, 32'd10, "cmp_lo10", rd);
        applyStimulus(0, 1'b1, 2'd3, 32'd0, "cmp_hi0", rd);
        idle(12);
        checkOutput("irq_high_const", {63'd0, irq_s[0]}, 64'd1);
        applyStimulus(0, 1'b1, 2'd3, 32'hFFFF_FFFF, "cmp_hi_max", rd);
        checkOutput("irq_low_const", {63'd0, irq_s[0]}, 64'd0);

        // Carry from low to high word with PRESCALE=4.
        applyStimulus(1, 1'b1, 2'd1, 32'd0, "mt_hi0", rd);
        waitAlign(1, 1);
        applyStimulus(1, 1'b1, 2'd0, 32'hFFFF_FFFF, "mt_lo_max", rd);
        idle(1);
        applyStimulus(1, 1'b0, 2'd1, 32'd0, "carry_hi", rd);
        checkOutput("carry_hi_const", {32'd0, rd}, 64'd1);
        applyStimulus(1, 1'b0, 2'd0, 32'd0, "carry_lo", rd);
        checkOutput("carry_lo_const", {32'd0, rd}, 64'd0);

        // Write on a tick edge suppresses that increment.
        applyStimulus(1, 1'b1, 2'd1, 32'd0, "mt_hi_clr", rd);
        waitAlign(1, 0);
        applyStimulus(1, 1'b1, 2'd0, 32'd100, "mt_lo100", rd);
        applyStimulus(1, 1'b0, 2'd0, 32'd0, "rd100", rd);
        checkOutput("rd100_const", {32'd0, rd}, 64'd100);
        applyStimulus(1, 1'b0, 2'd0, 32'd0, "rd101", rd);
        checkOutput("rd101_const", {32'd0, rd}, 64'd101);

        // Request held high: one ack every other cycle.
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 2'd0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_s[0]) acks++;
            checkOutput($sformatf("held_ack%0d", i), {63'd0, ack_s[0]}, (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i % 2 == 0)
                checkOutput($sformatf("held_rdata%0d", i), {32'd0, rdata_s[0]},
                            {32'd0, model_word(0, 2'd0, edge_n - 1)});
            checkIrqs();
        end
        req_s[0] = 1'b0;
        checkOutput("held_ack_count", 64'(acks), 64'd3);
        idle(1);

        // Reset lands on the acceptance edge of a write: abandoned.
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 2'd2; wdata_s[0] = 32'd5;
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("abandon_ack", {63'd0, ack_s[0]}, 64'd0);
        req_s[0] = 1'b0; we_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        applyStimulus(0, 1'b0, 2'd2, 32'd0, "abandon_cmp", rd);
        checkOutput("abandon_cmp_const", {32'd0, rd}, 64'hFFFF_FFFF);

        // Random traffic on both instances.
        for (int i = 0; i < 80; i++) begin
            d  = int'($urandom_range(0, 1));
            w  = 1'($urandom);
            a  = 2'($urandom);
            wd = ($urandom % 2 == 0) ? $urandom : $urandom_range(0, 60);
            applyStimulus(d, w, a, wd, $sformatf("rnd%0d", i), rd);
            idle(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
